// File: rtl/imem_load_ctrl.sv
// Instruction-RAM owner: boots the core by streaming a program image into the
// single-port RAM, then serves fetches with a fixed one-cycle read latency.
module imem_load_ctrl #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_hold,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] len_q;
  logic            load_ready_q;
  logic            load_done_q;
  logic            load_err_q;
  logic            cpu_hold_q;
  logic            fvalid_q;
  logic            ffault_q;

  logic            len_legal_s;
  logic            start_ok_s;
  logic            start_bad_s;
  logic            xfer_s;
  logic            last_s;
  logic            fetch_acc_s;
  logic            fetch_bad_s;

  // load_start is ignored while a load is already in progress
  assign len_legal_s = (load_len != {(ADDR_W+1){1'b0}}) && (load_len <= DEPTH);
  assign start_ok_s  = load_start && len_legal_s  && (state_q != ST_LOAD);
  assign start_bad_s = load_start && !len_legal_s && (state_q != ST_LOAD);

  assign xfer_s = (state_q == ST_LOAD) && load_valid && load_ready_q;
  assign last_s = xfer_s && (cnt_q == (len_q - CNT_ONE));

  // A legal load_start in RUN takes the RAM port, so a same-cycle fetch is dropped
  assign fetch_acc_s = (state_q == ST_RUN) && fetch_req && !start_ok_s;
  assign fetch_bad_s = (fetch_addr[1:0] != 2'b00) ||
                       (fetch_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});

  // Boot sequencer, load-side handshake and fetch response tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {(ADDR_W+1){1'b0}};
      len_q        <= {(ADDR_W+1){1'b0}};
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      fvalid_q     <= 1'b0;
      ffault_q     <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      fvalid_q    <= fetch_acc_s;
      ffault_q    <= fetch_acc_s && fetch_bad_s;

      if (start_bad_s) begin
        load_err_q <= 1'b1;
      end else if (start_ok_s) begin
        load_err_q <= 1'b0;
      end else begin
        load_err_q <= load_err_q;
      end

      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (start_ok_s) begin
            state_q      <= ST_LOAD;
            len_q        <= load_len;
            cnt_q        <= {(ADDR_W+1){1'b0}};
            load_ready_q <= 1'b1;
            cpu_hold_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (last_s) begin
              state_q      <= ST_RUN;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
              cpu_hold_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          load_ready_q <= 1'b0;
          cpu_hold_q   <= 1'b1;
        end
      endcase
    end
  end

  // RAM port: writes only during LOAD, reads only for accepted fetches
  assign mem_we    = xfer_s;
  assign mem_addr  = (state_q == ST_LOAD) ? cnt_q[ADDR_W-1:0] :
                     fetch_acc_s          ? fetch_addr[ADDR_W+1:2] :
                                            {ADDR_W{1'b0}};
  assign mem_wdata = (state_q == ST_LOAD) ? load_data : {DATA_W{1'b0}};

  // RAM data arrives the cycle after the address, so the response mux sits after it
  assign fetch_data  = !fvalid_q ? {DATA_W{1'b0}} :
                       ffault_q  ? NOP_WORD       : mem_rdata;
  assign fetch_valid = fvalid_q;
  assign fetch_fault = ffault_q;
  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign cpu_hold    = cpu_hold_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: behavioural sync RAM, write/fetch scoreboards,
// a fetch vector table and hand-written load/reset sequences.
module tb_imem_load_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_start, load_valid, fetch_req;
  logic [AW:0]   load_len;
  logic [DW-1:0] load_data;
  logic [31:0]   fetch_addr;
  logic          load_ready, load_done, load_err, cpu_hold;
  logic          fetch_valid, fetch_fault, mem_we;
  logic [DW-1:0] fetch_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  imem_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_len(load_len), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .load_err(load_err), .cpu_hold(cpu_hold),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic fault; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] addr; logic exp_fault; logic [31:0] exp_data; } fvec_t;

  wr_t   wq[$];
  rsp_t  fq[$];
  wr_t   mon_w;
  rsp_t  mon_r;
  fvec_t vecs[10];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | (i * 32'h0001_0003);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic [31:0] a);
    load_valid = 1'b1;
    load_data  = d;
    wq.push_back('{addr: a, data: d});
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic f, input logic [31:0] d);
    fetch_req  = 1'b1;
    fetch_addr = a;
    fq.push_back('{fault: f, data: d});
    tick();
    fetch_req = 1'b0;
  endtask

  // Scoreboard: every RAM write and every fetch response must be expected, in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_mem_we", {31'b0, mem_we}, 32'd0);
        else begin
          mon_w = wq.pop_front();
          chk("wr_addr", {24'b0, mem_addr}, mon_w.addr);
          chk("wr_data", mem_wdata, mon_w.data);
        end
      end
      if (fetch_valid) begin
        if (fq.size() == 0) chk("unexpected_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        else begin
          mon_r = fq.pop_front();
          chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, mon_r.fault});
          chk("fetch_data", fetch_data, mon_r.data);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, pat(0)};
    vecs[1] = '{32'h0000_0004, 1'b0, pat(1)};
    vecs[2] = '{32'h0000_0008, 1'b0, pat(2)};
    vecs[3] = '{32'h0000_000C, 1'b0, pat(3)};
    vecs[4] = '{32'h0000_03FC, 1'b0, pat(255)};
    vecs[5] = '{32'h0000_0002, 1'b1, NOP};
    vecs[6] = '{32'h0000_0400, 1'b1, NOP};
    vecs[7] = '{32'h8000_0000, 1'b1, NOP};
    vecs[8] = '{32'h0000_0201, 1'b1, NOP};
    vecs[9] = '{32'h0000_0010, 1'b0, pat(4)};

    load_start = 1'b0; load_len = '0; load_valid = 1'b0; load_data = '0;
    fetch_req = 1'b0; fetch_addr = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_fetch_data", fetch_data, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Illegal lengths in IDLE: error flagged, still holding the core
    load_start = 1'b1; load_len = 9'd0;
    tick();
    load_start = 1'b0;
    chk("len0_err", {31'b0, load_err}, 32'd1);
    chk("len0_hold", {31'b0, cpu_hold}, 32'd1);
    chk("len0_ready", {31'b0, load_ready}, 32'd0);
    load_start = 1'b1; load_len = 9'd257;
    tick();
    load_start = 1'b0;
    chk("len257_err", {31'b0, load_err}, 32'd1);
    chk("len257_ready", {31'b0, load_ready}, 32'd0);
    chk("len257_hold", {31'b0, cpu_hold}, 32'd1);

    // Legal 3-word load with continuous valid
    load_start = 1'b1; load_len = 9'd3;
    tick();
    load_start = 1'b0;
    chk("load3_err_clr", {31'b0, load_err}, 32'd0);
    chk("load3_ready", {31'b0, load_ready}, 32'd1);
    chk("load3_hold", {31'b0, cpu_hold}, 32'd1);
    load_word(32'h0000_0013, 32'd0);
    load_word(32'h0010_0093, 32'd1);
    load_word(32'h0000_0073, 32'd2);
    chk("load3_done", {31'b0, load_done}, 32'd1);
    chk("load3_hold_rel", {31'b0, cpu_hold}, 32'd0);
    chk("load3_ready_off", {31'b0, load_ready}, 32'd0);
    tick();
    chk("load3_done_pulse", {31'b0, load_done}, 32'd0);

    // In-flight fetch survives; fetch concurrent with load_start is dropped
    do_fetch(32'h0, 1'b0, 32'h0000_0013);
    fetch_req = 1'b1; fetch_addr = 32'h4;
    load_start = 1'b1; load_len = 9'd2;
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    chk("reload_hold", {31'b0, cpu_hold}, 32'd1);
    chk("reload_ready", {31'b0, load_ready}, 32'd1);
    load_word(32'hCAFE_0001, 32'd0);
    tick();
    tick();
    load_word(32'hCAFE_0002, 32'd1);
    chk("load2_done", {31'b0, load_done}, 32'd1);
    chk("load2_hold_rel", {31'b0, cpu_hold}, 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    fq.push_back('{fault: 1'b0, data: 32'hCAFE_0001});
    tick();
    fetch_addr = 32'h4;
    fq.push_back('{fault: 1'b0, data: 32'hCAFE_0002});
    tick();
    do_fetch(32'h8, 1'b0, 32'h0000_0073);
    tick();

    // Illegal length in RUN keeps the core running
    load_start = 1'b1; load_len = 9'd0;
    tick();
    load_start = 1'b0;
    chk("run_len0_err", {31'b0, load_err}, 32'd1);
    chk("run_len0_hold", {31'b0, cpu_hold}, 32'd0);
    chk("run_len0_ready", {31'b0, load_ready}, 32'd0);

    // Full-depth load: counter must terminate at 256 without wrapping
    load_start = 1'b1; load_len = 9'd256;
    tick();
    load_start = 1'b0;
    chk("full_err_clr", {31'b0, load_err}, 32'd0);
    chk("full_ready", {31'b0, load_ready}, 32'd1);
    for (int i = 0; i < 256; i++) load_word(pat(i), i);
    chk("full_done", {31'b0, load_done}, 32'd1);
    chk("full_hold_rel", {31'b0, cpu_hold}, 32'd0);

    // Table of back-to-back fetches, good and faulting addresses mixed
    for (int i = 0; i < 10; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = vecs[i].addr;
      fq.push_back('{fault: vecs[i].exp_fault, data: vecs[i].exp_data});
      tick();
    end
    fetch_req = 1'b0;
    tick();
    tick();
    chk("fetch_idle", {31'b0, fetch_valid}, 32'd0);

    // Reset in the middle of a load
    load_start = 1'b1; load_len = 9'd5;
    tick();
    load_start = 1'b0;
    load_word(32'h1111_0000, 32'd0);
    load_word(32'h1111_0001, 32'd1);
    load_valid = 1'b1; load_data = 32'h1111_0002;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_ready", {31'b0, load_ready}, 32'd0);
    chk("midrst_hold", {31'b0, cpu_hold}, 32'd1);
    chk("midrst_done", {31'b0, load_done}, 32'd0);
    chk("midrst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    load_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_hold", {31'b0, cpu_hold}, 32'd1);
    chk("postrst_ready", {31'b0, load_ready}, 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();

    chk("wq_empty", wq.size(), 32'd0);
    chk("fq_empty", fq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
